pipe_hazard_ctrl: RTL

- Hazard and sequencing controller for the 5-stage pipelined CPU (IF/ID/EXE/MEM/WB).
- Keeps its own shadow copy of the destination-register info for instructions in flight in EXE and MEM.
- From that state it produces:
  - operand forwarding selects (A_DEPEN/B_DEPEN style codes),
  - the load-use stall (DEPEN),
  - PC source selection and IF squash for branches and jumps,
  - interlock for a multi-cycle multiply/divide unit (MDU).
- Sits beside the ID stage and drives the PC/IR write enables and the EXE operand muxes.

---
 rtl/cpu_pipe_pkg.sv | 43 ++++
 rtl/mdu_scoreboard.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the 5-stage pipeline control logic.
//   REG_W       : register-number width
//   FWD_*       : EXE operand-mux select codes
//   PCS_*       : PC source select codes
//   fwd_sel()   : forwarding select for one source operand
package cpu_pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXE   = 2'b01;
  localparam logic [1:0] FWD_MEM   = 2'b10;
  localparam logic [1:0] FWD_MEMLD = 2'b11;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JR  = 2'b10;
  localparam logic [1:0] PCS_J   = 2'b11;

  // EXE wins over MEM; register 0 never forwards. A load still in EXE gives
  // no select here because it causes a stall instead.
  function automatic logic [1:0] fwd_sel(
    input logic             use_src,
    input logic [REG_W-1:0] src,
    input logic             e_wreg,
    input logic             e_m2reg,
    input logic [REG_W-1:0] e_rn,
    input logic             m_wreg,
    input logic             m_m2reg,
    input logic [REG_W-1:0] m_rn
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_src) begin
      if (e_wreg && (e_rn != '0) && (e_rn == src) && !e_m2reg)
        sel = FWD_EXE;
      else if (m_wreg && (m_rn != '0) && (m_rn == src))
        sel = m_m2reg ? FWD_MEMLD : FWD_MEM;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mdu_scoreboard.sv
// Tracks the multi-cycle multiply/divide unit.
//   clock, reset  : system clock, synchronous active-high reset
//   mdu_load      : an MDU op is leaving ID this cycle (already stall-qualified)
//   id_valid      : ID holds a real instruction
//   id_mdu_use    : ID instruction needs the MDU result / unit
//   mdu_busy      : operation in progress
//   md_stall      : ID must wait for the MDU
module mdu_scoreboard #(
  parameter int MDU_LAT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic mdu_load,
  input  logic id_valid,
  input  logic id_mdu_use,
  output logic mdu_busy,
  output logic md_stall
);

  logic [3:0] count;

  // A load in the same cycle the count reaches zero simply reloads it.
  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (mdu_load)
      count <= 4'(MDU_LAT - 1);
    else if (count != '0)
      count <= count - 4'd1;
  end

  assign mdu_busy = (count != '0);
  assign md_stall = mdu_busy & id_mdu_use & id_valid;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the IF/ID/EXE/MEM/WB pipeline.
// Keeps a shadow of the EXE/MEM destination info and derives forwarding
// selects, load-use and MDU stalls, PC source and IF squash.
//   clock, reset          : system clock, synchronous active-high reset
//   id_*                  : decoded fields of the instruction in ID
//   wpcir                 : PC and IF/ID write enable (0 = stall)
//   fwda, fwdb            : EXE operand A/B selects
//   exe_load              : EXE holds a register-writing load
//   pcsource              : next-PC select
//   flush_if              : bubble the IF/ID contents on the next edge
//   mdu_busy              : MDU operation in progress
module pipe_hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int DELAY_SLOT = 1,
  parameter int MDU_LAT    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [REG_W-1:0] id_rn,
  input  logic             id_btaken,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic             id_mdu_start,
  input  logic             id_mdu_use,
  output logic             wpcir,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             exe_load,
  output logic [1:0]       pcsource,
  output logic             flush_if,
  output logic             mdu_busy
);

  logic             e_wreg, e_m2reg, m_wreg, m_m2reg;
  logic [REG_W-1:0] e_rn, m_rn;
  logic             lu, md, stall, issue;

  assign lu = e_wreg & e_m2reg & (e_rn != '0) &
              ((id_use_rs & (e_rn == id_rs)) | (id_use_rt & (e_rn == id_rt)));

  assign stall = id_valid & (lu | md);
  assign issue = id_valid & ~stall;
  assign wpcir = ~stall;

  // A stalled instruction enters EXE as a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      e_wreg  <= 1'b0;
      e_m2reg <= 1'b0;
      e_rn    <= '0;
      m_wreg  <= 1'b0;
      m_m2reg <= 1'b0;
      m_rn    <= '0;
    end else begin
      m_wreg  <= e_wreg;
      m_m2reg <= e_m2reg;
      m_rn    <= e_rn;
      e_wreg  <= id_wreg & issue;
      e_m2reg <= id_m2reg & issue;
      e_rn    <= issue ? id_rn : '0;
    end
  end

  mdu_scoreboard #(.MDU_LAT(MDU_LAT)) u_mdu (
    .clock      (clock),
    .reset      (reset),
    .mdu_load   (id_mdu_start & issue),
    .id_valid   (id_valid),
    .id_mdu_use (id_mdu_use),
    .mdu_busy   (mdu_busy),
    .md_stall   (md)
  );

  assign fwda = fwd_sel(id_use_rs, id_rs, e_wreg, e_m2reg, e_rn, m_wreg, m_m2reg, m_rn);
  assign fwdb = fwd_sel(id_use_rt, id_rt, e_wreg, e_m2reg, e_rn, m_wreg, m_m2reg, m_rn);

  assign exe_load = e_wreg & e_m2reg;

  // A stalled branch/jump is not redirected until its operands are ready.
  always_comb begin
    pcsource = PCS_SEQ;
    if (issue) begin
      if (id_jr)          pcsource = PCS_JR;
      else if (id_jump)   pcsource = PCS_J;
      else if (id_btaken) pcsource = PCS_BR;
    end
  end

  assign flush_if = (DELAY_SLOT == 0) && (pcsource != PCS_SEQ);

endmodule
